mmio_io_ctrl: RTL
=================

Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the cpu memory bus (mem_cmd/mem_addr/write_data/read_data) and board I/O.
- Decodes RAM vs I/O space and provides N_OUT registered output ports (LED-style) and N_IN synchronised input ports (switch-style).
- Adds per-input sticky rising-edge capture with clear-on-read, plus output readback.
- Read data has one-cycle latency, aligned with the RAM block's registered dout.

Parameters:
- DATA_W, 16, bus data width
- ADDR_W, 9, bus address width; MSB=1 selects I/O space, MSB=0 selects RAM
- PORT_W, 8, width of each I/O port (PORT_W <= DATA_W)
- N_OUT, 2, number of output ports
- N_IN, 2, number of input ports
- OUT_BASE, 9'h100, address of output port 0
- IN_BASE, 9'h140, address of input port 0

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- mem_cmd  input  2  bus command: MWRITE=2'b00, MREAD=2'b01, MNONE=2'b10
- mem_addr  input  ADDR_W  bus address
- wdata  input  DATA_W  write data from cpu
- in_port  input  N_IN*PORT_W  asynchronous board inputs; port i at [i*PORT_W +: PORT_W]
- out_port  output  N_OUT*PORT_W  registered output ports
- rdata  output  DATA_W  I/O read data, valid when rd_en=1
- rd_en  output  1  drive enable for the top-level tristate onto read_data
- ram_write  output  1  combinational: mem_cmd==MWRITE && mem_addr[ADDR_W-1]==0
- ram_read  output  1  combinational: mem_cmd==MREAD && mem_addr[ADDR_W-1]==0

Behaviour:
- Reset (reset==0 at a clk edge): out_port=0, rdata=0, rd_en=0, synchroniser flops=0, edge flags=0. Reset overrides any same-cycle bus command.
- Address map (I/O space only):
  - OUT_BASE+i, i<N_OUT: output register i, read/write.
  - IN_BASE+i, i<N_IN: synchronised input i, read-only.
  - IN_BASE+N_IN+i: edge-flag word i, read-only, clear-on-read.
- Write (mem_cmd==MWRITE, address hits output reg i): out_port[i] <= wdata[PORT_W-1:0] at the clk edge, visible the next cycle. Writes to input/edge/unmapped I/O addresses are ignored.
- Read (mem_cmd==MREAD, I/O address): at the edge, rdata <= selected value zero-extended to DATA_W, and rd_en <= 1. Unmapped I/O addresses return 0 with rd_en=1.
- When there is no I/O read in a cycle, rd_en <= 0 and rdata <= 0. Latency is exactly 1 cycle; back-to-back reads are supported every cycle.
- Input path: 2-flop synchroniser per bit. Reads return the second-stage value, so in_port changes are visible on a read issued >= 2 cycles later.
- Edge flags: bit b of flag i sets when the synchronised bit goes 0->1 (second stage vs a third delayed stage). Flags are sticky.
  - A read of edge word i clears it at the same edge; rdata carries the pre-clear value.
  - Simultaneous new edge and clear: the flag stays set (set wins).
- Output readback returns the current register value. A same-cycle read and write to the same output register returns the old value.
- RAM region: ram_write/ram_read assert; rd_en stays 0 and I/O state is unchanged.
- mem_cmd==MNONE or 2'b11: no action; ram_write=ram_read=0.
- Elaboration constraints: output, input and edge ranges must not overlap and must lie in I/O space. Violations are flagged with an elaboration-time $error.

Decomposition:
- Package mmio_pkg:
  - mem_cmd_t enum (MWRITE, MREAD, MNONE)
  - default base-address constants
  - a function giving the port index from an address
- Sub-module io_in_sync (parameter W): 2-flop synchroniser plus delay flop and rising-edge pulse output. Instantiated once per input port via a generate loop.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles -> out_port=0, rd_en=0, rdata=0; on reset=1 with MNONE, outputs stay 0.
- Output write/readback: MWRITE 0x100 wdata=16'hABCD, then MREAD 0x100 -> out_port[7:0]=8'hCD next cycle; rdata=16'h00CD with rd_en=1 one cycle after the read; out_port[15:8] stays 0.
- Input sync latency: set in_port[7:0]=8'h5A at cycle t; MREAD 0x140 at t+1 -> rdata=0; MREAD at t+2 -> rdata=16'h005A the following cycle.
- Edge capture and clear-on-read: in_port[8] goes 0->1, wait 4 cycles.
  - MREAD 0x143 -> rdata=16'h0001; a second read -> 16'h0000.
  - A repeat run with a new 0->1 edge on bit 8 timed to the clearing cycle -> the second read returns 16'h0001.
- Decode split: MWRITE 0x040 -> ram_write=1, out_port unchanged. MREAD 0x1F0 -> ram_read=0, rd_en=1, rdata=0.
- Reset mid-operation: MREAD 0x100 issued in the same cycle reset=0 -> rd_en=0 and out_port=0 next cycle; an edge flag set beforehand reads back 0 after reset.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-mapped I/O controller.
package mmio_pkg;

  // Bus command encoding. 2'b11 is unused and treated like MNONE.
  typedef enum logic [1:0] {
    MWRITE = 2'b00,
    MREAD  = 2'b01,
    MNONE  = 2'b10
  } mem_cmd_t;

  // Default base addresses inside the I/O half of a 9-bit address space.
  localparam logic [8:0] DEF_OUT_BASE = 9'h100;
  localparam logic [8:0] DEF_IN_BASE  = 9'h140;

  // Offset of an address from a region base. Addresses below the base wrap
  // to a large value, so they never match a small port index.
  function automatic int unsigned port_index(input int unsigned addr,
                                             input int unsigned base);
    return addr - base;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_in_sync.sv
// Input conditioning for one board input port: a two-flop synchroniser,
// a third delay flop, and a rising-edge pulse derived from stages two/three.
module io_in_sync
  import mmio_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  // Synchroniser chain plus one extra stage used only for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: splits the cpu bus between RAM and I/O space,
// holds the output port registers, synchronises the input ports, and keeps
// sticky rising-edge flags that clear when read.
//
// Read handshake: an I/O read presented on the bus in cycle n is answered in
// cycle n+1 with rd_en=1 and rdata holding the value; in every other cycle
// rd_en=0 and rdata=0. There is no back-pressure, so a read may be issued
// every cycle.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               ADDR_W   = 9,
  parameter int               PORT_W   = 8,
  parameter int               N_OUT    = 2,
  parameter int               N_IN     = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE = DEF_OUT_BASE,
  parameter logic [ADDR_W-1:0] IN_BASE  = DEF_IN_BASE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [N_IN*PORT_W-1:0]  in_port,
  output logic [N_OUT*PORT_W-1:0] out_port,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rd_en,
  output logic                    ram_write,
  output logic                    ram_read
);

  // Address-map bounds, used for the elaboration checks below.
  localparam int OUT_LO = 32'(OUT_BASE);
  localparam int OUT_HI = OUT_LO + N_OUT - 1;
  localparam int IN_LO  = 32'(IN_BASE);
  localparam int IN_HI  = IN_LO + 2 * N_IN - 1;
  localparam int IO_LO  = 2 ** (ADDR_W - 1);
  localparam int IO_HI  = 2 ** ADDR_W - 1;

  if (N_OUT < 1 || N_IN < 1) begin : g_bad_count
    $error("mmio_io_ctrl: N_OUT and N_IN must be at least 1");
  end
  if (PORT_W > DATA_W) begin : g_bad_width
    $error("mmio_io_ctrl: PORT_W must not exceed DATA_W");
  end
  if (OUT_LO < IO_LO || OUT_HI > IO_HI) begin : g_bad_out
    $error("mmio_io_ctrl: output range lies outside I/O space");
  end
  if (IN_LO < IO_LO || IN_HI > IO_HI) begin : g_bad_in
    $error("mmio_io_ctrl: input/edge range lies outside I/O space");
  end
  if (OUT_LO <= IN_HI && IN_LO <= OUT_HI) begin : g_bad_overlap
    $error("mmio_io_ctrl: output range overlaps input/edge range");
  end

  // State
  logic [PORT_W-1:0] r_out  [N_OUT];
  logic [PORT_W-1:0] r_flag [N_IN];

  // Decode and datapath wires
  logic              w_io;
  logic              w_rd;
  logic              w_wr;
  int unsigned       w_out_idx;
  int unsigned       w_in_idx;
  int unsigned       w_edge_idx;
  logic [N_OUT-1:0]  w_out_sel;
  logic [N_IN-1:0]   w_in_sel;
  logic [N_IN-1:0]   w_edge_sel;
  logic [N_IN-1:0]   w_clr;
  logic [DATA_W-1:0] w_rd_val;
  logic [PORT_W-1:0] w_sync [N_IN];
  logic [PORT_W-1:0] w_rise [N_IN];
  logic              w_unused_wdata;

  // Only the low PORT_W bits of a write reach a port register.
  assign w_unused_wdata = |wdata;

  // Per-port input synchroniser and edge detector.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    io_in_sync #(.W(PORT_W)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (in_port[gi*PORT_W +: PORT_W]),
      .o_sync  (w_sync[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  // Flatten the output registers onto the board port.
  for (genvar go = 0; go < N_OUT; go++) begin : g_out
    assign out_port[go*PORT_W +: PORT_W] = r_out[go];
  end

  // Region split and command qualification.
  always_comb begin
    w_io      = mem_addr[ADDR_W-1];
    w_rd      = (mem_cmd == MREAD)  && w_io;
    w_wr      = (mem_cmd == MWRITE) && w_io;
    ram_read  = (mem_cmd == MREAD)  && !w_io;
    ram_write = (mem_cmd == MWRITE) && !w_io;
  end

  // Register selection within I/O space.
  always_comb begin
    w_out_idx  = port_index(32'(mem_addr), 32'(OUT_BASE));
    w_in_idx   = port_index(32'(mem_addr), 32'(IN_BASE));
    w_edge_idx = port_index(32'(mem_addr), 32'(IN_BASE) + 32'(N_IN));
    w_out_sel  = '0;
    w_in_sel   = '0;
    w_edge_sel = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_out_sel[i] = w_io && (w_out_idx == 32'(i));
    end
    for (int i = 0; i < N_IN; i++) begin
      w_in_sel[i]   = w_io && (w_in_idx == 32'(i));
      w_edge_sel[i] = w_io && (w_edge_idx == 32'(i));
    end
  end

  // Read mux; unmapped I/O addresses fall through to zero. Edge flags are
  // returned before the clear that the same read triggers.
  always_comb begin
    w_rd_val = '0;
    w_clr    = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_out_sel[i]) w_rd_val[PORT_W-1:0] = r_out[i];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (w_in_sel[i])   w_rd_val[PORT_W-1:0] = w_sync[i];
      if (w_edge_sel[i]) w_rd_val[PORT_W-1:0] = r_flag[i];
      w_clr[i] = w_rd && w_edge_sel[i];
    end
  end

  // Output port registers; writes to any other I/O address are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_OUT; i++) r_out[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_wr && w_out_sel[i]) r_out[i] <= wdata[PORT_W-1:0];
      end
    end
  end

  // Sticky edge flags: a new rising edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) r_flag[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        r_flag[i] <= (r_flag[i] & ~{PORT_W{w_clr[i]}}) | w_rise[i];
      end
    end
  end

  // One-cycle read response register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_en <= 1'b0;
      rdata <= '0;
    end else begin
      rd_en <= w_rd;
      rdata <= w_rd ? w_rd_val : '0;
    end
  end

endmodule
